// File: rtl/rr_hold_arbiter.sv
// Multi-cycle round-robin arbiter with grant hold, bounded bursts and zero-bubble hand-over.
// Optional macro RR_ARB_GNT_ID_EN adds gnt_id_o, the registered binary index of the owner.
module rr_hold_arbiter #(
  parameter  int N         = 32,
  parameter  int MAX_BURST = 8,
  localparam int IW        = $clog2(N),
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic          busy_o,
`ifdef RR_ARB_GNT_ID_EN
  output logic [IW-1:0] gnt_id_o,
`endif
  output logic [0:0]    dbg_state_o,
  output logic [IW-1:0] dbg_ptr_o
);

  // Handshake: a requester raises req_i[i] and holds it for the whole transfer;
  // it owns the resource in every cycle gnt_o[i]=1 while req_i[i]=1, and must
  // ignore gnt_o[i] in the single cycle after it drops req_i[i].

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;

  logic          others, expire, keep;
  logic [IW-1:0] next_start, search_start;
  logic [IW:0]   pick;

  // Returns {found, index} of the first set bit at start, start+1, ... with wrap.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(start) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    others       = |(req_i & ~(N'(1) << own_q));
    expire       = (cnt_q == BW'(MAX_BURST)) && others;
    keep         = req_i[own_q] && !expire;
    next_start   = (own_q == IW'(N - 1)) ? '0 : own_q + IW'(1);
    search_start = (state_q == IDLE) ? ptr_q : next_start;
    pick         = rr_pick(req_i, search_start);

    case (state_q)
      IDLE: begin
        if (pick[IW]) begin
          state_d = OWN;
          own_d   = pick[IW-1:0];
          cnt_d   = BW'(1);
        end
      end
      OWN: begin
        if (keep) begin
          if (cnt_q != BW'(MAX_BURST)) cnt_d = cnt_q + BW'(1);
        end else begin
          // On expiry the wrapped search reaches the owner last, so a waiter always wins.
          ptr_d = next_start;
          if (pick[IW]) begin
            own_d = pick[IW-1:0];
            cnt_d = BW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    gnt_d  = (state_d == OWN) ? (N'(1) << own_d) : '0;
    busy_d = (state_d == OWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RR_ARB_GNT_ID_EN
  logic [IW-1:0] gnt_id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gnt_id_q <= '0;
    else       gnt_id_q <= (state_d == OWN) ? own_d : '0;
  end

  assign gnt_id_o = gnt_id_q;
`endif

  assign gnt_o       = gnt_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule
